// File: rtl/packet_assembler_pkg.sv
// -----------------------------------------------------------------------------
// packet_assembler_pkg
// Shared definitions for the UART packet path. The transmit and receive sides
// both import this package, so they agree on the CRC-8 polynomial, its seed
// and the per-bit update.
//   - pa_state_e : receive framing FSM states
//   - CRC8_POLY  : CRC-8 generator polynomial (x^8 + x^2 + x + 1)
//   - CRC8_INIT  : CRC register seed
//   - crc8_step  : one-bit MSB-first CRC-8 update (no reflection)
// -----------------------------------------------------------------------------
package packet_assembler_pkg;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COLLECT   = 3'd1,
        AWAIT_CRC = 3'd2,
        CHECK     = 3'd3,
        DELIVER   = 3'd4
    } pa_state_e;

    // One shift of an MSB-first CRC-8: the feedback bit is the outgoing MSB
    // XORed with the incoming message bit.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic din);
        logic fb;
        fb = crc_in[7] ^ din;
        crc8_step = {crc_in[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/packet_assembler_crc8.sv
// -----------------------------------------------------------------------------
// crc8_serial
// Bit-serial CRC-8 engine. A start strobe loads the message and seeds the CRC
// register. After that, the engine consumes one message bit per clock, MSB
// first. After the last bit it raises done_o for exactly one cycle. While
// done_o is high, crc_o holds the final CRC.
// Ports:
//   clk, reset  : system clock, asynchronous active-high reset
//   start_i     : one-cycle strobe, loads data_i and restarts the engine
//   data_i      : message to be checked (sampled on start_i)
//   done_o      : one-cycle pulse, crc_o is final
//   crc_o       : CRC register contents
// -----------------------------------------------------------------------------
module crc8_serial
    import packet_assembler_pkg::*;
#(
    parameter int DATA_W = 48
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              done_o,
    output logic [7:0]        crc_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [7:0]        crc_q,   crc_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    // Next-state: load on start, otherwise shift one bit per cycle while busy.
    always_comb begin
        shift_d = shift_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (start_i) begin
            shift_d = data_i;
            crc_d   = CRC8_INIT;
            cnt_d   = CNT_W'(DATA_W);
            busy_d  = 1'b1;
        end else if (busy_q) begin
            crc_d   = crc8_step(crc_q, shift_q[DATA_W-1]);
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
            cnt_d   = cnt_q - CNT_W'(1);
            // The last shift happens on this edge, so done lines up with the final CRC.
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Engine state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            crc_q   <= CRC8_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign done_o = done_q;
    assign crc_o  = crc_q;

endmodule

// File: rtl/packet_assembler.sv
// -----------------------------------------------------------------------------
// packet_assembler
// Receive-side frame builder. It takes UART bytes and assembles SEGMENT_COUNT
// payload bytes, LSB byte first, followed by one CRC-8 byte. It checks the CRC
// serially. A good payload is offered on a valid/ready port. A bad or stalled
// frame is dropped and reported with a one-cycle error pulse.
// Ports:
//   clk, reset     : system clock, asynchronous active-high reset
//   rx_data        : byte from the UART receiver
//   rx_valid       : one-cycle strobe, rx_data is new
//   msg_data       : assembled payload, stable while msg_valid is high
//   msg_valid      : payload available
//   msg_ready      : consumer accepts (transfer on msg_valid & msg_ready)
//   crc_error      : pulse, frame dropped on CRC mismatch
//   timeout_error  : pulse, frame dropped on inter-byte silence
//   overrun        : pulse, byte arrived while checking/delivering and was dropped
// -----------------------------------------------------------------------------
module packet_assembler
    import packet_assembler_pkg::*;
#(
    parameter int DATA_LENGTH    = 8,
    parameter int MESSAGE_LENGTH = 48,
    parameter int CRC_LENGTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_LENGTH-1:0]    rx_data,
    input  logic                      rx_valid,
    output logic [MESSAGE_LENGTH-1:0] msg_data,
    output logic                      msg_valid,
    input  logic                      msg_ready,
    output logic                      crc_error,
    output logic                      timeout_error,
    output logic                      overrun
);

    localparam int SEGMENT_COUNT = MESSAGE_LENGTH / DATA_LENGTH;
    localparam int CNT_W         = $clog2(SEGMENT_COUNT + 1);
    localparam int TMO_W         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEGMENT_COUNT - 1);

    pa_state_e                 state_q,     state_d;
    logic [MESSAGE_LENGTH-1:0] payload_q,   payload_d;
    logic [CNT_W-1:0]          byte_cnt_q,  byte_cnt_d;
    logic [TMO_W-1:0]          tmo_q,       tmo_d;
    logic [CRC_LENGTH-1:0]     crc_rx_q,    crc_rx_d;
    logic                      msg_valid_q, msg_valid_d;
    logic                      crc_err_q,   crc_err_d;
    logic                      tmo_err_q,   tmo_err_d;
    logic                      overrun_q,   overrun_d;

    logic                      wr_byte_s;
    logic                      crc_start_s;
    logic                      crc_done_s;
    logic [7:0]                crc_calc_s;

    // The payload register feeds the checker directly. It is frozen from CRC
    // start until delivery, so the checker does not need its own copy.
    crc8_serial #(
        .DATA_W (MESSAGE_LENGTH)
    ) u_crc8_serial (
        .clk     (clk),
        .reset   (reset),
        .start_i (crc_start_s),
        .data_i  (payload_q),
        .done_o  (crc_done_s),
        .crc_o   (crc_calc_s)
    );

    // Framing FSM: next state, counters and error pulses.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        tmo_d       = '0;
        crc_rx_d    = crc_rx_q;
        msg_valid_d = msg_valid_q;
        crc_err_d   = 1'b0;
        tmo_err_d   = 1'b0;
        overrun_d   = 1'b0;
        wr_byte_s   = 1'b0;
        crc_start_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    wr_byte_s  = 1'b1;
                    byte_cnt_d = CNT_W'(1);
                    state_d    = COLLECT;
                end else begin
                    state_d = IDLE;
                end
            end
            COLLECT: begin
                // The expiry check comes first, so a byte on the expiry edge is lost.
                if (tmo_q == TMO_LAST) begin
                    tmo_err_d  = 1'b1;
                    byte_cnt_d = '0;
                    state_d    = IDLE;
                end else if (rx_valid) begin
                    wr_byte_s  = 1'b1;
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    if (byte_cnt_q == CNT_LAST) begin
                        state_d = AWAIT_CRC;
                    end else begin
                        state_d = COLLECT;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            AWAIT_CRC: begin
                if (tmo_q == TMO_LAST) begin
                    tmo_err_d  = 1'b1;
                    byte_cnt_d = '0;
                    state_d    = IDLE;
                end else if (rx_valid) begin
                    crc_rx_d    = rx_data[CRC_LENGTH-1:0];
                    crc_start_s = 1'b1;
                    byte_cnt_d  = '0;
                    state_d     = CHECK;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            CHECK: begin
                overrun_d = rx_valid;
                if (crc_done_s) begin
                    if (crc_calc_s == crc_rx_q) begin
                        msg_valid_d = 1'b1;
                        state_d     = DELIVER;
                    end else begin
                        crc_err_d = 1'b1;
                        state_d   = IDLE;
                    end
                end else begin
                    state_d = CHECK;
                end
            end
            DELIVER: begin
                overrun_d = rx_valid;
                if (msg_ready) begin
                    msg_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    msg_valid_d = 1'b1;
                    state_d     = DELIVER;
                end
            end
            default: begin
                msg_valid_d = 1'b0;
                byte_cnt_d  = '0;
                state_d     = IDLE;
            end
        endcase
    end

    // Payload write: the byte counter selects the byte lane, LSB byte first.
    always_comb begin
        payload_d = payload_q;
        for (int k = 0; k < SEGMENT_COUNT; k++) begin
            payload_d[k*DATA_LENGTH +: DATA_LENGTH] =
                (wr_byte_s && (byte_cnt_q == CNT_W'(k))) ? rx_data
                                                         : payload_q[k*DATA_LENGTH +: DATA_LENGTH];
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            payload_q   <= '0;
            byte_cnt_q  <= '0;
            tmo_q       <= '0;
            crc_rx_q    <= '0;
            msg_valid_q <= 1'b0;
            crc_err_q   <= 1'b0;
            tmo_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            payload_q   <= payload_d;
            byte_cnt_q  <= byte_cnt_d;
            tmo_q       <= tmo_d;
            crc_rx_q    <= crc_rx_d;
            msg_valid_q <= msg_valid_d;
            crc_err_q   <= crc_err_d;
            tmo_err_q   <= tmo_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign msg_data      = payload_q;
    assign msg_valid     = msg_valid_q;
    assign crc_error     = crc_err_q;
    assign timeout_error = tmo_err_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_packet_assembler.sv
// -----------------------------------------------------------------------------
// tb_packet_assembler
// Self-checking bench for packet_assembler (TIMEOUT_CYCLES overridden to 50).
// Expected payloads go into a queue when a frame is sent. A negedge monitor
// pops and compares them on each transfer. The monitor also counts error
// pulses and checks that msg_data is held while msg_valid waits for ready.
// -----------------------------------------------------------------------------
module tb_packet_assembler;

    localparam int TMO = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [47:0] msg_data;
    logic        msg_valid;
    logic        msg_ready;
    logic        crc_error;
    logic        timeout_error;
    logic        overrun;

    int tests = 0;
    int fails = 0;
    int crc_err_cnt = 0;
    int tmo_cnt = 0;
    int ovr_cnt = 0;
    int deliv_cnt = 0;
    logic [47:0] exp_q[$];

    typedef struct {
        logic [47:0] payload;
        logic [7:0]  crc_xor;
        int          gap;
        logic        exp_deliver;
        logic        exp_crc_err;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    packet_assembler #(
        .DATA_LENGTH    (8),
        .MESSAGE_LENGTH (48),
        .CRC_LENGTH     (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .msg_data      (msg_data),
        .msg_valid     (msg_valid),
        .msg_ready     (msg_ready),
        .crc_error     (crc_error),
        .timeout_error (timeout_error),
        .overrun       (overrun)
    );

    // Reference CRC-8 (poly 07, init 00), byte-wise, highest payload byte first.
    function automatic logic [7:0] crc8_ref(input logic [47:0] p);
        logic [7:0] c;
        c = 8'h00;
        for (int bi = 5; bi >= 0; bi--) begin
            c = c ^ p[8*bi +: 8];
            for (int b = 0; b < 8; b++) begin
                c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
            end
        end
        return c;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_payload(input logic [47:0] p, input int nbytes, input int gap);
        for (int k = 0; k < nbytes; k++) begin
            send_byte(p[8*k +: 8]);
            repeat (gap) tick();
        end
    endtask

    task automatic send_frame(input logic [47:0] p, input logic [7:0] crc, input int gap, input logic push);
        send_payload(p, 6, gap);
        if (push) exp_q.push_back(p);
        send_byte(crc);
    endtask

    // Monitor: scoreboard pops, pulse counters, hold and exclusivity checks.
    initial begin
        logic        prev_hold;
        logic [47:0] prev_data;
        logic [47:0] exp_data;
        prev_hold = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (crc_error)     crc_err_cnt++;
            if (timeout_error) tmo_cnt++;
            if (overrun)       ovr_cnt++;
            if (timeout_error) check("tmo_excl", {62'd0, crc_error, overrun}, 64'd0);
            if (prev_hold && msg_valid) check("hold_data", {16'd0, msg_data}, {16'd0, prev_data});
            if (msg_valid && msg_ready) begin
                deliv_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL deliver: unexpected payload %h, none expected", msg_data);
                end else begin
                    exp_data = exp_q.pop_front();
                    check("deliver_data", {16'd0, msg_data}, {16'd0, exp_data});
                end
            end
            prev_hold = msg_valid && !msg_ready && !reset;
            prev_data = msg_data;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int k;
        int bc;
        int bt;
        int bo;
        int bd;
        logic held_ok;

        vecs[0] = '{payload: 48'h0123_4567_89AB, crc_xor: 8'h00, gap: 0,       exp_deliver: 1'b1, exp_crc_err: 1'b0};
        vecs[1] = '{payload: 48'hFFFF_FFFF_FFFF, crc_xor: 8'h00, gap: 2,       exp_deliver: 1'b1, exp_crc_err: 1'b0};
        vecs[2] = '{payload: 48'h8000_0000_0000, crc_xor: 8'h00, gap: 0,       exp_deliver: 1'b1, exp_crc_err: 1'b0};
        vecs[3] = '{payload: 48'hA5A5_5A5A_C3C3, crc_xor: 8'h01, gap: 1,       exp_deliver: 1'b0, exp_crc_err: 1'b1};
        vecs[4] = '{payload: 48'h1357_9BDF_2468, crc_xor: 8'h80, gap: 0,       exp_deliver: 1'b0, exp_crc_err: 1'b1};
        vecs[5] = '{payload: 48'h0F0E_0D0C_0B0A, crc_xor: 8'h00, gap: TMO - 2, exp_deliver: 1'b1, exp_crc_err: 1'b0};
        vecs[6] = '{payload: 48'h0000_0000_0100, crc_xor: 8'h00, gap: 3,       exp_deliver: 1'b1, exp_crc_err: 1'b0};

        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        msg_ready = 1'b1;
        tick();
        tick();
        check("rst_msg_valid", {63'd0, msg_valid}, 64'd0);
        check("rst_msg_data", {16'd0, msg_data}, 64'd0);
        check("rst_crc_error", {63'd0, crc_error}, 64'd0);
        check("rst_timeout", {63'd0, timeout_error}, 64'd0);
        check("rst_overrun", {63'd0, overrun}, 64'd0);
        reset = 1'b0;
        tick();

        // Test 1: basic frame, 50-cycle latency from the CRC strobe.
        bc = crc_err_cnt; bd = deliv_cnt;
        send_payload(48'h0000_0000_0001, 6, 0);
        exp_q.push_back(48'h0000_0000_0001);
        send_byte(8'h07);
        lat = 1;
        while (!msg_valid && lat < 200) begin
            tick();
            lat++;
        end
        check("t1_latency", lat, 50);
        check("t1_data", {16'd0, msg_data}, 64'h0000_0000_0000_0001);
        repeat (5) tick();
        check("t1_crc_err", crc_err_cnt - bc, 0);
        check("t1_delivered", deliv_cnt - bd, 1);

        // Test 2: back-pressure holds msg_valid and msg_data.
        msg_ready = 1'b0;
        send_frame(48'h0, 8'h00, 0, 1'b1);
        k = 0;
        while (!msg_valid && k < 100) begin
            tick();
            k++;
        end
        check("t2_valid", {63'd0, msg_valid}, 64'd1);
        held_ok = 1'b1;
        repeat (20) begin
            tick();
            if (!msg_valid || msg_data !== 48'h0) held_ok = 1'b0;
        end
        check("t2_hold", {63'd0, held_ok}, 64'd1);
        msg_ready = 1'b1;
        tick();
        check("t2_cleared", {63'd0, msg_valid}, 64'd0);

        // Test 3: bad CRC dropped, the next frame is accepted.
        bc = crc_err_cnt; bd = deliv_cnt;
        send_payload(48'h0000_0000_0001, 6, 0);
        send_byte(8'h08);
        repeat (60) tick();
        check("t3_crc_err", crc_err_cnt - bc, 1);
        check("t3_no_deliver", deliv_cnt - bd, 0);
        send_frame(48'h0000_0000_00A5, crc8_ref(48'h0000_0000_00A5), 1, 1'b1);
        repeat (60) tick();
        check("t3_next_ok", deliv_cnt - bd, 1);

        // Test 4: silence after three bytes times out exactly TMO cycles later.
        bt = tmo_cnt; bd = deliv_cnt; bc = crc_err_cnt;
        send_payload(48'h0000_0003_0201, 3, 0);
        k = 0;
        while (!timeout_error && k < 200) begin
            tick();
            k++;
        end
        check("t4_tmo_time", k, TMO);
        repeat (3) tick();
        check("t4_tmo_pulse", tmo_cnt - bt, 1);
        send_frame(48'h0, 8'h00, 0, 1'b1);
        repeat (60) tick();
        check("t4_next_ok", deliv_cnt - bd, 1);
        check("t4_no_crc_err", crc_err_cnt - bc, 0);

        // Test 5: extra bytes during CHECK and DELIVER are dropped with overrun.
        bo = ovr_cnt; bd = deliv_cnt; bc = crc_err_cnt;
        msg_ready = 1'b0;
        send_frame(48'hDEAD_BEEF_1234, crc8_ref(48'hDEAD_BEEF_1234), 0, 1'b1);
        repeat (10) tick();
        send_byte(8'hFF);
        k = 0;
        while (!msg_valid && k < 100) begin
            tick();
            k++;
        end
        send_byte(8'hEE);
        repeat (3) tick();
        check("t5_overrun", ovr_cnt - bo, 2);
        check("t5_data", {16'd0, msg_data}, {16'd0, 48'hDEAD_BEEF_1234});
        msg_ready = 1'b1;
        repeat (3) tick();
        check("t5_delivered", deliv_cnt - bd, 1);
        check("t5_no_crc_err", crc_err_cnt - bc, 0);
        check("t5_valid_low", {63'd0, msg_valid}, 64'd0);

        // Test 6: reset mid-frame clears everything; the next frame is clean.
        bd = deliv_cnt; bc = crc_err_cnt; bt = tmo_cnt;
        send_payload(48'h0000_0403_0201, 4, 0);
        reset = 1'b1;
        #2;
        check("t6_rst_data", {16'd0, msg_data}, 64'd0);
        check("t6_rst_flags", {59'd0, msg_valid, crc_error, timeout_error, overrun, 1'b0}, 64'd0);
        tick();
        reset = 1'b0;
        tick();
        send_frame(48'h0000_0000_0001, 8'h07, 0, 1'b1);
        repeat (60) tick();
        check("t6_delivered", deliv_cnt - bd, 1);
        check("t6_no_errors", (crc_err_cnt - bc) + (tmo_cnt - bt), 0);

        // Test 7: byte on the expiry edge loses to the timeout, with no overrun.
        bt = tmo_cnt; bo = ovr_cnt; bd = deliv_cnt; bc = crc_err_cnt;
        send_payload(48'h0000_0000_7766, 2, 0);
        repeat (TMO - 1) tick();
        send_byte(8'h55);
        repeat (3) tick();
        check("t7_tmo", tmo_cnt - bt, 1);
        check("t7_no_overrun", ovr_cnt - bo, 0);
        send_frame(48'h0000_0000_0001, 8'h07, 0, 1'b1);
        repeat (60) tick();
        check("t7_next_ok", deliv_cnt - bd, 1);
        check("t7_no_crc_err", crc_err_cnt - bc, 0);

        // Table-driven frames.
        for (int i = 0; i < 7; i++) begin
            bc = crc_err_cnt; bd = deliv_cnt; bt = tmo_cnt;
            send_frame(vecs[i].payload, crc8_ref(vecs[i].payload) ^ vecs[i].crc_xor,
                       vecs[i].gap, vecs[i].exp_deliver);
            repeat (60) tick();
            check($sformatf("vec%0d_deliver", i), deliv_cnt - bd, {63'd0, vecs[i].exp_deliver});
            check($sformatf("vec%0d_crc_err", i), crc_err_cnt - bc, {63'd0, vecs[i].exp_crc_err});
            check($sformatf("vec%0d_no_tmo", i), tmo_cnt - bt, 0);
        end

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
